// File: rtl/calc_controller_if.sv
// rtl/calc_controller_if.sv - keypad, ALU handshake and display signals of the calculator controller
interface calc_controller_if #(
    parameter int WIDTH = 16
);
    logic             dig_strobe;
    logic             reset_strobe;
    logic             ex_strobe;
    logic             op_strobe;
    logic [3:0]       dig_code;
    logic [1:0]       op_code;
    logic             alu_start;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_err;
    logic [WIDTH-1:0] disp_value;
    logic             disp_err;
    logic             busy;

    modport master (
        input  dig_strobe, reset_strobe, ex_strobe, op_strobe, dig_code, op_code,
        input  alu_done, alu_result, alu_err,
        output alu_start, alu_a, alu_b, alu_op, disp_value, disp_err, busy
    );

    modport slave (
        output dig_strobe, reset_strobe, ex_strobe, op_strobe, dig_code, op_code,
        output alu_done, alu_result, alu_err,
        input  alu_start, alu_a, alu_b, alu_op, disp_value, disp_err, busy
    );
endinterface

// File: rtl/calc_controller.sv
// rtl/calc_controller.sv - keypad-to-ALU sequencing controller
// Builds decimal operands, launches ALU operations over start/done and drives the display.
module calc_controller #(
    parameter int WIDTH = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    calc_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_ENTRY_A, S_ENTRY_B, S_WAIT, S_DRAIN, S_RESULT, S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, opa_q, opa_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0]       pend_op_q, pend_op_d, next_op_q, next_op_d, alu_op_q, alu_op_d;
    logic             has_dig_q, has_dig_d, next_vld_q, next_vld_d, start_q, start_d;
    logic [WIDTH+3:0] acc_wide, acc_next;
    logic             dig_ok, done_ok, launch, clr_all;

    // Four spare bits hold acc*10+9 exactly, so any carry out of WIDTH means overflow.
    assign acc_wide = {4'b0000, acc_q};
    assign acc_next = (acc_wide << 3) + (acc_wide << 1) + {{WIDTH{1'b0}}, bus.dig_code};
    assign dig_ok   = (bus.dig_code <= 4'd9) && (acc_next[WIDTH+3:WIDTH] == 4'b0000);
    assign done_ok  = bus.alu_done && !start_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        opa_d      = opa_q;
        pend_op_d  = pend_op_q;
        next_op_d  = next_op_q;
        next_vld_d = next_vld_q;
        has_dig_d  = has_dig_q;
        launch     = 1'b0;
        clr_all    = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (done_ok && bus.reset_strobe) begin
                    clr_all = 1'b1;
                end else if (done_ok && bus.alu_err) begin
                    state_d = S_ERROR;
                end else if (done_ok) begin
                    opa_d     = bus.alu_result;
                    acc_d     = '0;
                    has_dig_d = 1'b0;
                    if (next_vld_q) begin
                        pend_op_d  = next_op_q;
                        next_vld_d = 1'b0;
                        state_d    = S_ENTRY_B;
                    end else begin
                        state_d = S_RESULT;
                    end
                end else if (bus.reset_strobe) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: clr_all = done_ok;
            default: begin
                if (bus.reset_strobe) begin
                    acc_d     = '0;
                    opa_d     = '0;
                    has_dig_d = 1'b0;
                    state_d   = S_ENTRY_A;
                end else if (state_q == S_ERROR) begin
                    state_d = S_ERROR;
                end else if (bus.ex_strobe) begin
                    if (state_q == S_ENTRY_B && has_dig_q) begin
                        launch     = 1'b1;
                        next_vld_d = 1'b0;
                    end
                end else if (bus.op_strobe) begin
                    if (state_q == S_ENTRY_B && has_dig_q) begin
                        launch     = 1'b1;
                        next_op_d  = bus.op_code;
                        next_vld_d = 1'b1;
                    end else begin
                        if (state_q == S_ENTRY_A) opa_d = acc_q;
                        pend_op_d = bus.op_code;
                        acc_d     = '0;
                        has_dig_d = 1'b0;
                        state_d   = S_ENTRY_B;
                    end
                end else if (bus.dig_strobe) begin
                    if (state_q == S_RESULT && bus.dig_code <= 4'd9) begin
                        acc_d     = {{(WIDTH-4){1'b0}}, bus.dig_code};
                        has_dig_d = 1'b1;
                        state_d   = S_ENTRY_A;
                    end else if (state_q != S_RESULT && dig_ok) begin
                        acc_d     = acc_next[WIDTH-1:0];
                        has_dig_d = 1'b1;
                    end
                end
            end
        endcase
        if (launch) state_d = S_WAIT;
        if (clr_all) begin
            acc_d      = '0;
            opa_d      = '0;
            pend_op_d  = '0;
            next_op_d  = '0;
            next_vld_d = 1'b0;
            has_dig_d  = 1'b0;
            state_d    = S_ENTRY_A;
        end
        start_d  = launch;
        alu_a_d  = launch ? opa_q : (clr_all ? '0 : alu_a_q);
        alu_b_d  = launch ? acc_q : (clr_all ? '0 : alu_b_q);
        alu_op_d = launch ? pend_op_q : (clr_all ? 2'b00 : alu_op_q);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_ENTRY_A;
            acc_q      <= '0;
            opa_q      <= '0;
            pend_op_q  <= '0;
            next_op_q  <= '0;
            next_vld_q <= 1'b0;
            has_dig_q  <= 1'b0;
            start_q    <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            opa_q      <= opa_d;
            pend_op_q  <= pend_op_d;
            next_op_q  <= next_op_d;
            next_vld_q <= next_vld_d;
            has_dig_q  <= has_dig_d;
            start_q    <= start_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
        end
    end

    always_comb begin
        case (state_q)
            S_ENTRY_A:        bus.disp_value = acc_q;
            S_ENTRY_B:        bus.disp_value = has_dig_q ? acc_q : opa_q;
            S_WAIT, S_RESULT: bus.disp_value = opa_q;
            default:          bus.disp_value = '0;
        endcase
    end

    assign bus.alu_start = start_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.disp_err  = (state_q == S_ERROR);
    assign bus.busy      = (state_q == S_WAIT) || (state_q == S_DRAIN);
endmodule

// File: tb/tb_calc_controller.sv
// tb/tb_calc_controller.sv - self-checking bench for calc_controller
module tb_calc_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   start_cnt = 0;

    calc_controller_if #(.WIDTH(16)) bus ();
    calc_controller #(.WIDTH(16)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) if (bus.alu_start === 1'b1) start_cnt++;

    task automatic key(input logic d, input logic o, input logic e, input logic r,
                       input logic [3:0] dc, input logic [1:0] oc);
        @(negedge clk);
        bus.dig_strobe = d; bus.op_strobe = o; bus.ex_strobe = e; bus.reset_strobe = r;
        bus.dig_code = dc; bus.op_code = oc;
        @(negedge clk);
        bus.dig_strobe = 0; bus.op_strobe = 0; bus.ex_strobe = 0; bus.reset_strobe = 0;
    endtask

    task automatic dig(input int d); key(1, 0, 0, 0, 4'(d), 2'd0); endtask
    task automatic op(input int c);  key(0, 1, 0, 0, 4'd0, 2'(c)); endtask
    task automatic ex();             key(0, 0, 1, 0, 4'd0, 2'd0); endtask
    task automatic clr();            key(0, 0, 0, 1, 4'd0, 2'd0); endtask

    task automatic type_num(input int n);
        int ds[$];
        int v;
        v = n;
        if (v == 0) ds.push_front(0);
        while (v > 0) begin ds.push_front(v % 10); v = v / 10; end
        foreach (ds[i]) dig(ds[i]);
    endtask

    // Unsigned 16-bit calculator arithmetic as the ALU defines it.
    function automatic void model(input longint a, input int o, input longint b,
                                  output longint r, output bit e);
        r = 0; e = 0;
        case (o)
            0: r = a + b;
            1: begin r = a - b; e = (b > a); end
            2: r = a * b;
            default: begin e = (b == 0); r = (b == 0) ? 0 : a / b; end
        endcase
        if (r > 65535) e = 1;
    endfunction

    task automatic alu_respond(input int ea, input int eb, input int eo,
                               input int res, input bit err, input int dly);
        int n = 0;
        while (bus.alu_start !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        checks++;
        if (bus.alu_start !== 1'b1) begin
            failures++; $display("FAIL alu_start_timeout got=%b exp=1", bus.alu_start); return;
        end
        checks++;
        if (bus.alu_a !== 16'(ea) || bus.alu_b !== 16'(eb) || bus.alu_op !== 2'(eo)) begin
            failures++;
            $display("FAIL launch_operands got=%0d,%0d,%0d exp=%0d,%0d,%0d",
                     bus.alu_a, bus.alu_b, bus.alu_op, ea, eb, eo);
        end
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_at_start got=%b exp=1", bus.busy); end
        repeat (dly) @(negedge clk);
        checks++;
        if (bus.alu_a !== 16'(ea) || bus.alu_b !== 16'(eb) || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL operand_hold got=%0d,%0d busy=%b exp=%0d,%0d busy=1", bus.alu_a, bus.alu_b, bus.busy, ea, eb);
        end
        bus.alu_done = 1; bus.alu_result = 16'(res); bus.alu_err = err;
        @(negedge clk);
        bus.alu_done = 0; bus.alu_result = 16'hdead; bus.alu_err = 0;
    endtask

    task automatic expect_disp(input string nm, input int v, input bit e, input bit b);
        checks++;
        if (bus.disp_value !== 16'(v) || bus.disp_err !== e || bus.busy !== b) begin
            failures++;
            $display("FAIL %s got disp=%0d err=%b busy=%b exp disp=%0d err=%b busy=%b",
                     nm, bus.disp_value, bus.disp_err, bus.busy, v, e, b);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.disp_value !== 0 || bus.disp_err !== 0 || bus.busy !== 0 || bus.alu_start !== 0 ||
            bus.alu_a !== 0 || bus.alu_b !== 0 || bus.alu_op !== 0) begin
            failures++;
            $display("FAIL reset_values got disp=%0d err=%b busy=%b start=%b a=%0d b=%0d op=%0d exp all 0",
                     bus.disp_value, bus.disp_err, bus.busy, bus.alu_start, bus.alu_a, bus.alu_b, bus.alu_op);
        end
        rst = 0;
    endtask

    task automatic test_basic();
        int s0;
        dig(1); expect_disp("basic_d1", 1, 0, 0);
        dig(2); expect_disp("basic_d12", 12, 0, 0);
        op(0);  expect_disp("basic_op", 12, 0, 0);
        type_num(34); expect_disp("basic_b", 34, 0, 0);
        s0 = start_cnt;
        ex();
        alu_respond(12, 34, 0, 46, 0, 2);
        expect_disp("basic_result", 46, 0, 0);
        checks++;
        if (start_cnt - s0 !== 1) begin failures++; $display("FAIL start_pulses got=%0d exp=1", start_cnt - s0); end
    endtask

    task automatic test_chain();
        clr(); dig(5); op(2); dig(6); op(1);
        alu_respond(5, 6, 2, 30, 0, 1);
        expect_disp("chain_mid", 30, 0, 0);
        dig(4); expect_disp("chain_b", 4, 0, 0);
        ex();
        alu_respond(30, 4, 1, 26, 0, 3);
        expect_disp("chain_final", 26, 0, 0);
    endtask

    task automatic test_overflow();
        clr(); type_num(6553); expect_disp("ovf_6553", 6553, 0, 0);
        dig(5); expect_disp("ovf_65535", 65535, 0, 0);
        dig(0); expect_disp("ovf_drop", 65535, 0, 0);
        clr(); dig(1); key(1, 0, 0, 0, 4'd12, 2'd0); expect_disp("bad_digit", 1, 0, 0);
    endtask

    task automatic test_error();
        int s0;
        clr(); dig(9); op(3); dig(0); ex();
        alu_respond(9, 0, 3, 16'hbeef, 1, 1);
        expect_disp("err_state", 0, 1, 0);
        s0 = start_cnt;
        dig(3); op(0); dig(1); ex();
        expect_disp("err_sticky", 0, 1, 0);
        checks++;
        if (start_cnt !== s0) begin failures++; $display("FAIL err_no_launch got=%0d exp=%0d", start_cnt, s0); end
        clr(); expect_disp("err_clear", 0, 0, 0);
    endtask

    task automatic test_drain();
        clr(); dig(3); op(0); dig(4); ex();
        clr();
        expect_disp("drain_busy", 0, 0, 1);
        @(negedge clk); @(negedge clk);
        expect_disp("drain_hold", 0, 0, 1);
        bus.alu_done = 1; bus.alu_result = 16'd7;
        @(negedge clk); bus.alu_done = 0;
        expect_disp("drain_done", 0, 0, 0);
        checks++;
        if (bus.alu_a !== 0 || bus.alu_b !== 0) begin
            failures++; $display("FAIL drain_operands got=%0d,%0d exp=0,0", bus.alu_a, bus.alu_b);
        end
        dig(8); expect_disp("drain_entry", 8, 0, 0);
    endtask

    task automatic test_replace_op();
        clr(); dig(7); op(0); op(1); expect_disp("repl_opa", 7, 0, 0);
        dig(2); ex();
        alu_respond(7, 2, 1, 5, 0, 1);
        expect_disp("repl_result", 5, 0, 0);
    endtask

    task automatic test_priority();
        int s0;
        clr(); dig(2); op(0); dig(3);
        key(1, 1, 1, 0, 4'd9, 2'd2);
        alu_respond(2, 3, 0, 5, 0, 1);
        expect_disp("prio_ex_result", 5, 0, 0);
        dig(7); s0 = start_cnt; ex();
        @(negedge clk);
        checks++;
        if (start_cnt !== s0 || bus.busy !== 0) begin
            failures++; $display("FAIL prio_ex_not_chained got starts=%0d busy=%b exp starts=%0d busy=0", start_cnt, bus.busy, s0);
        end
        clr(); dig(1); key(1, 1, 0, 0, 4'd5, 2'd0); expect_disp("prio_op_over_dig", 1, 0, 0);
        key(1, 1, 1, 1, 4'd5, 2'd0); expect_disp("prio_reset", 0, 0, 0);
    endtask

    task automatic test_async_reset();
        int s0;
        clr(); dig(1); op(0); dig(1); ex();
        rst = 1; #1;
        checks++;
        if (bus.busy !== 0 || bus.alu_start !== 0 || bus.alu_a !== 0 || bus.disp_value !== 0) begin
            failures++;
            $display("FAIL async_reset got busy=%b start=%b a=%0d disp=%0d exp 0", bus.busy, bus.alu_start, bus.alu_a, bus.disp_value);
        end
        s0 = start_cnt;
        @(negedge clk); rst = 0;
        @(negedge clk); bus.alu_done = 1; bus.alu_result = 16'd2;
        @(negedge clk); bus.alu_done = 0;
        expect_disp("async_late_done", 0, 0, 0);
        checks++;
        if (start_cnt !== s0) begin failures++; $display("FAIL async_no_start got=%0d exp=%0d", start_cnt, s0); end
    endtask

    task automatic test_random();
        longint v[4];
        int     o[3];
        int     k;
        longint cur, r;
        bit     e;
        for (int it = 0; it < 12; it++) begin
            k = $urandom_range(1, 3);
            for (int j = 0; j < 4; j++)
                v[j] = ($urandom % 4 == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 300);
            for (int j = 0; j < 3; j++) o[j] = $urandom_range(0, 3);
            e = 0;
            clr(); type_num(int'(v[0])); expect_disp("rnd_first", int'(v[0]), 0, 0);
            cur = v[0];
            for (int i = 0; i < k && !e; i++) begin
                op(o[i]);
                if (i > 0) begin
                    model(cur, o[i-1], v[i], r, e);
                    alu_respond(int'(cur), int'(v[i]), o[i-1], e ? 16'hbeef : int'(r), e, $urandom_range(1, 4));
                    if (!e) begin cur = r; expect_disp("rnd_chain", int'(cur), 0, 0); end
                end
                if (!e) begin type_num(int'(v[i+1])); expect_disp("rnd_operand", int'(v[i+1]), 0, 0); end
            end
            if (!e) begin
                ex();
                model(cur, o[k-1], v[k], r, e);
                alu_respond(int'(cur), int'(v[k]), o[k-1], e ? 16'hbeef : int'(r), e, $urandom_range(1, 4));
                if (!e) cur = r;
            end
            expect_disp("rnd_final", e ? 0 : int'(cur), e, 0);
        end
    endtask

    initial begin
        bus.dig_strobe = 0; bus.op_strobe = 0; bus.ex_strobe = 0; bus.reset_strobe = 0;
        bus.dig_code = 0; bus.op_code = 0;
        bus.alu_done = 0; bus.alu_result = 0; bus.alu_err = 0;
        test_reset();
        test_basic();
        test_chain();
        test_overflow();
        test_error();
        test_drain();
        test_replace_op();
        test_priority();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
